// File: rtl/exc_pkg.sv
// Exception controller shared definitions: FSM state encoding, ESR codes and
// the default handler entry address.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    HANDLER,
    HOLD,
    HALT
  } exc_state_t;

  localparam logic [3:0] ESR_NONE    = 4'b0000;
  localparam logic [3:0] ESR_IRQ     = 4'b0001;
  localparam logic [3:0] ESR_INVALID = 4'b0010;

  localparam logic [63:0] VECTOR_ADDR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exc_holdoff_cnt.sv
// IRQ holdoff down-counter: load presets the count, tick decrements toward
// zero, done flags the terminal count.
module exc_holdoff_cnt #(
  parameter logic [3:0] LOAD_VAL = 4'd1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (tick && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt entry controller. Define EXC_HOLDOFF_EN to build the
// post-ERET IRQ holdoff (HOLD state and exc_holdoff_cnt).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | normal execution, watching for IRQ / invalid opcode / ERET
// ENTER   | one-cycle redirect of fetch to ExcVector
// HANDLER | executing the handler, IRQ masked
// HOLD    | IRQ masked for HOLDOFF cycles after ERET
// HALT    | double fault, only reset leaves
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned     PC_W        = 64,
  parameter logic [PC_W-1:0] VECTOR_ADDR = PC_W'(VECTOR_ADDR_DEFAULT),
  parameter int unsigned     HOLDOFF     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ExtIRQ,
  input  logic            ExcInvalid,
  input  logic            ERet,
  input  logic [PC_W-1:0] PC,
  output logic            ExcTaken,
  output logic [PC_W-1:0] ExcVector,
  output logic [PC_W-1:0] ELR,
  output logic [3:0]      ESR,
  output logic            ExtAck,
  output logic            InHandler,
  output logic            Halt
);

  if ((HOLDOFF < 1) || (HOLDOFF > 15)) begin : g_holdoff_range
    $error("exc_ctrl: HOLDOFF must be within 1..15");
  end

  exc_state_t      state, state_nxt;
  logic [PC_W-1:0] elr_q, elr_nxt;
  logic [3:0]      esr_q, esr_nxt;
  logic            ack_q, ack_nxt;

`ifdef EXC_HOLDOFF_EN
  logic hold_load;
  logic hold_done;

  exc_holdoff_cnt #(
    .LOAD_VAL (4'(HOLDOFF - 1))
  ) u_holdoff_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .tick  (state == HOLD),
    .done  (hold_done)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      elr_q <= '0;
      esr_q <= ESR_NONE;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      elr_q <= elr_nxt;
      esr_q <= esr_nxt;
      ack_q <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    elr_nxt   = elr_q;
    esr_nxt   = esr_q;
    // Ack drops the cycle after the source is seen deasserted.
    ack_nxt   = ack_q & ExtIRQ;
`ifdef EXC_HOLDOFF_EN
    hold_load = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ExtIRQ) begin
          state_nxt = ENTER;
          elr_nxt   = PC;
          esr_nxt   = ESR_IRQ;
          ack_nxt   = 1'b1;
        end else if (ExcInvalid || ERet) begin
          state_nxt = ENTER;
          elr_nxt   = PC;
          esr_nxt   = ESR_INVALID;
        end
      end
      ENTER: begin
        state_nxt = HANDLER;
      end
      HANDLER: begin
        if (ERet) begin
`ifdef EXC_HOLDOFF_EN
          state_nxt = HOLD;
          hold_load = 1'b1;
`else
          state_nxt = IDLE;
`endif
        end else if (ExcInvalid) begin
          state_nxt = HALT;
          esr_nxt   = ESR_INVALID;
          ack_nxt   = 1'b0;
        end
      end
`ifdef EXC_HOLDOFF_EN
      HOLD: begin
        if (ExcInvalid || ERet) begin
          state_nxt = ENTER;
          elr_nxt   = PC;
          esr_nxt   = ESR_INVALID;
        end else if (hold_done) begin
          state_nxt = IDLE;
        end
      end
`endif
      HALT: begin
        ack_nxt = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ExcTaken  = (state == ENTER);
  assign InHandler = (state == HANDLER);
  assign Halt      = (state == HALT);
  assign ExcVector = VECTOR_ADDR;
  assign ELR       = elr_q;
  assign ESR       = esr_q;
  assign ExtAck    = ack_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: each driven cycle pushes the expected
// outputs, which are popped and compared one clock later.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ExtIRQ;
  logic        ExcInvalid;
  logic        ERet;
  logic [63:0] PC;
  logic        ExcTaken;
  logic [63:0] ExcVector;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic        ExtAck;
  logic        InHandler;
  logic        Halt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        taken;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        ack;
    logic        inh;
    logic        halt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .ExcInvalid (ExcInvalid),
    .ERet       (ERet),
    .PC         (PC),
    .ExcTaken   (ExcTaken),
    .ExcVector  (ExcVector),
    .ELR        (ELR),
    .ESR        (ESR),
    .ExtAck     (ExtAck),
    .InHandler  (InHandler),
    .Halt       (Halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t e(input logic taken, input logic [63:0] elr, input logic [3:0] esr,
                             input logic ack, input logic inh, input logic halt);
    exp_t r;
    r.taken = taken; r.elr = elr; r.esr = esr; r.ack = ack; r.inh = inh; r.halt = halt;
    return r;
  endfunction

  task automatic cyc(input logic rst, input logic irq, input logic inv, input logic eret,
                     input logic [63:0] pc, input string tag, input exp_t x);
    exp_t  got;
    string t;
    reset = rst; ExtIRQ = irq; ExcInvalid = inv; ERet = eret; PC = pc;
    sb_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      t   = tag_q.pop_front();
      chk({t, ".ExcTaken"},  {63'd0, ExcTaken},  {63'd0, got.taken});
      chk({t, ".ELR"},       ELR,                got.elr);
      chk({t, ".ESR"},       {60'd0, ESR},       {60'd0, got.esr});
      chk({t, ".ExtAck"},    {63'd0, ExtAck},    {63'd0, got.ack});
      chk({t, ".InHandler"}, {63'd0, InHandler}, {63'd0, got.inh});
      chk({t, ".Halt"},      {63'd0, Halt},      {63'd0, got.halt});
    end
  endtask

  initial begin
    reset = 1'b1; ExtIRQ = 1'b0; ExcInvalid = 1'b0; ERet = 1'b0; PC = '0;

    cyc(1, 0, 0, 0, 64'h00, "reset_init",      e(0, 64'h00, 4'h0, 0, 0, 0));
    cyc(0, 1, 0, 0, 64'h40, "irq_enter",       e(1, 64'h40, 4'h1, 1, 0, 0));
    cyc(0, 0, 0, 0, 64'h44, "irq_handler",     e(0, 64'h40, 4'h1, 0, 1, 0));
    cyc(0, 1, 0, 0, 64'h48, "handler_ign_irq", e(0, 64'h40, 4'h1, 0, 1, 0));
    cyc(0, 1, 0, 1, 64'h4C, "eret",            e(0, 64'h40, 4'h1, 0, 0, 0));
`ifdef EXC_HOLDOFF_EN
    cyc(0, 1, 0, 0, 64'h50, "hold1_ign_irq",   e(0, 64'h40, 4'h1, 0, 0, 0));
    cyc(0, 1, 0, 0, 64'h54, "hold2_to_idle",   e(0, 64'h40, 4'h1, 0, 0, 0));
    cyc(0, 1, 0, 0, 64'h58, "reentry",         e(1, 64'h58, 4'h1, 1, 0, 0));
    cyc(0, 1, 0, 0, 64'h60, "ack_hold",        e(0, 64'h58, 4'h1, 1, 1, 0));
    cyc(0, 0, 0, 0, 64'h64, "ack_drop",        e(0, 64'h58, 4'h1, 0, 1, 0));
    cyc(0, 0, 1, 0, 64'h68, "halt_entry",      e(0, 64'h58, 4'h2, 0, 0, 1));
    cyc(0, 1, 1, 1, 64'h6C, "halt_stay",       e(0, 64'h58, 4'h2, 0, 0, 1));
`else
    cyc(0, 1, 0, 0, 64'h50, "reentry",         e(1, 64'h50, 4'h1, 1, 0, 0));
    cyc(0, 1, 0, 0, 64'h60, "ack_hold",        e(0, 64'h50, 4'h1, 1, 1, 0));
    cyc(0, 0, 0, 0, 64'h64, "ack_drop",        e(0, 64'h50, 4'h1, 0, 1, 0));
    cyc(0, 0, 1, 0, 64'h68, "halt_entry",      e(0, 64'h50, 4'h2, 0, 0, 1));
    cyc(0, 1, 1, 1, 64'h6C, "halt_stay",       e(0, 64'h50, 4'h2, 0, 0, 1));
`endif
    cyc(1, 1, 1, 0, 64'h70, "halt_reset",      e(0, 64'h00, 4'h0, 0, 0, 0));
    cyc(0, 0, 1, 0, 64'h88, "inv_enter",       e(1, 64'h88, 4'h2, 0, 0, 0));
    cyc(0, 0, 0, 0, 64'h8C, "inv_handler",     e(0, 64'h88, 4'h2, 0, 1, 0));
    cyc(1, 0, 0, 0, 64'h90, "handler_reset",   e(0, 64'h00, 4'h0, 0, 0, 0));
    cyc(0, 1, 1, 0, 64'h10, "irq_priority",    e(1, 64'h10, 4'h1, 1, 0, 0));
    cyc(1, 1, 0, 0, 64'h14, "enter_reset",     e(0, 64'h00, 4'h0, 0, 0, 0));
    cyc(0, 0, 0, 1, 64'h20, "eret_idle",       e(1, 64'h20, 4'h2, 0, 0, 0));
    cyc(0, 0, 0, 0, 64'h24, "eret_handler",    e(0, 64'h20, 4'h2, 0, 1, 0));
    cyc(0, 0, 0, 1, 64'h28, "eret_leave",      e(0, 64'h20, 4'h2, 0, 0, 0));
    cyc(0, 0, 1, 0, 64'h30, "inv_after_eret",  e(1, 64'h30, 4'h2, 0, 0, 0));
    cyc(0, 0, 0, 0, 64'h34, "inv_handler2",    e(0, 64'h30, 4'h2, 0, 1, 0));

    chk("ExcVector", ExcVector, 64'h0000_0000_0000_00D8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
